// File: rtl/hidden_layer_mac_if.sv
// Result stream from the hidden-layer engine to the output-layer stage.
// One 8-bit activation plus its neuron index per valid/ready transfer.
interface hidden_layer_mac_if #(
   parameter int IDX_W = 5
);
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic [IDX_W-1:0] out_idx;

   modport master (
      output out_valid,
      output out_data,
      output out_idx,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_idx,
      output out_ready
   );
endinterface

// File: rtl/hidden_layer_mac.sv
// hidden_layer_mac: sequential hidden-layer neuron engine, one signed 8x8 MAC per cycle, N_HID neurons per pass.
// Latency: N_IN+2 cycles per neuron with out_ready high; done pulses one cycle after the last accepted result.
// Backpressure: out_ready low holds the result and freezes addresses. Optional ReLU: define HIDDEN_MAC_RELU_EN.
module hidden_layer_mac #(
   parameter  int N_IN      = 64,
   parameter  int N_HID     = 30,
   parameter  int FRAC_BITS = 4,
   parameter  int ACC_W     = 24,
   localparam int X_AW      = $clog2(N_IN),
   localparam int W_AW      = $clog2(N_IN * N_HID),
   localparam int K_W       = $clog2(N_HID)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [8*N_HID-1:0]    bh_flat_i,
   output logic [X_AW-1:0]       x_addr_o,
   input  logic [7:0]            x_data_i,
   output logic [W_AW-1:0]       w_addr_o,
   input  logic [7:0]            w_data_i,
   output logic                  busy_o,
   output logic                  done_o,
   hidden_layer_mac_if.master    out_if
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BIAS = 2'd1,
      ACC  = 2'd2,
      OUT  = 2'd3
   } state_t;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);

   state_t state_q, state_d;

   logic [K_W-1:0]          k_q, k_d;
   logic [X_AW-1:0]         i_q, i_d;
   logic [W_AW-1:0]         w_addr_q, w_addr_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    out_valid_q, out_valid_d;
   logic [7:0]              out_data_q, out_data_d;
   logic [K_W-1:0]          out_idx_q, out_idx_d;

   logic                    last_i;
   logic                    last_k;
   logic                    xfer;
   logic [7:0]              bh_k;
   logic signed [ACC_W-1:0] bias_ext;
   logic signed [15:0]      prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] acc_sum;
   logic signed [ACC_W-1:0] r_shift;
   logic signed [ACC_W-1:0] r_act;
   logic [7:0]              sat_val;

   assign last_i = (i_q == X_AW'(N_IN - 1));
   assign last_k = (k_q == K_W'(N_HID - 1));
   assign xfer   = out_valid_q & out_if.out_ready;

   // Datapath: bias alignment, product, running sum and the final rescale.
   assign bh_k     = bh_flat_i[8*int'(k_q) +: 8];
   assign bias_ext = $signed({{(ACC_W-8){bh_k[7]}}, bh_k}) <<< FRAC_BITS;
   assign prod     = $signed(x_data_i) * $signed(w_data_i);
   assign prod_ext = $signed({{(ACC_W-16){prod[15]}}, prod});
   assign acc_sum  = acc_q + prod_ext;
   assign r_shift  = acc_sum >>> FRAC_BITS;

`ifdef HIDDEN_MAC_RELU_EN
   assign r_act = (r_shift < 0) ? '0 : r_shift;
`else
   assign r_act = r_shift;
`endif

   always_comb begin
      sat_val = r_act[7:0];
      if (r_act > SAT_MAX) begin
         sat_val = 8'h7F;
      end else if (r_act < SAT_MIN) begin
         sat_val = 8'h80;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start_i) state_d = BIAS;
         BIAS: state_d = ACC;
         ACC:  if (last_i) state_d = OUT;
         OUT:  if (xfer) state_d = last_k ? IDLE : BIAS;
         default: state_d = IDLE;
      endcase
   end

   // FSM output logic: next values for every datapath and output register.
   always_comb begin
      k_d         = k_q;
      i_d         = i_q;
      w_addr_d    = w_addr_q;
      acc_d       = acc_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               busy_d   = 1'b1;
               k_d      = '0;
               i_d      = '0;
               w_addr_d = '0;
            end
         end
         BIAS: begin
            acc_d = bias_ext;
         end
         ACC: begin
            acc_d = acc_sum;
            if (last_i) begin
               // Result is registered straight from the final sum so it is visible in OUT.
               out_data_d  = sat_val;
               out_idx_d   = k_q;
               out_valid_d = 1'b1;
            end else begin
               i_d      = i_q + X_AW'(1);
               w_addr_d = w_addr_q + W_AW'(1);
            end
         end
         OUT: begin
            if (xfer) begin
               out_valid_d = 1'b0;
               if (last_k) begin
                  busy_d = 1'b0;
                  done_d = 1'b1;
               end else begin
                  // w_addr sits on k*N_IN+N_IN-1, so +1 is the next neuron's base.
                  k_d      = k_q + K_W'(1);
                  i_d      = '0;
                  w_addr_d = w_addr_q + W_AW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_q         <= '0;
         i_q         <= '0;
         w_addr_q    <= '0;
         acc_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
      end else begin
         k_q         <= k_d;
         i_q         <= i_d;
         w_addr_q    <= w_addr_d;
         acc_q       <= acc_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
      end
   end

   assign x_addr_o         = i_q;
   assign w_addr_o         = w_addr_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign out_if.out_valid = out_valid_q;
   assign out_if.out_data  = out_data_q;
   assign out_if.out_idx   = out_idx_q;

   a_hold_while_stalled: assert property (
      @(posedge clk) disable iff (!rst_n)
      (out_valid_q && !out_if.out_ready) |=>
         (out_valid_q && $stable(out_data_q) && $stable(out_idx_q) && $stable(w_addr_q))
   );

   a_done_only_at_idle: assert property (
      @(posedge clk) disable iff (!rst_n)
      done_q |-> (state_q == IDLE && !busy_q)
   );

endmodule

// File: doc/hidden_layer_mac.md
Name: hidden_layer_mac

Overview:
- Sequential hidden-layer neuron engine: computes all N_HID hidden activations, one neuron at a time, one multiply-accumulate per cycle.
- Consumes the flattened hidden-bias bus driven by the bias memory stage, an input-feature ROM/RAM, and a hidden-weight ROM.
- For each neuron it adds the bias, rescales, applies activation and saturation, then streams the 8-bit result to the output-layer stage over a valid/ready handshake.

Parameters:
- N_IN, 64: input features per neuron.
- N_HID, 30: hidden neurons.
- FRAC_BITS, 4: fractional bits of the Q-format shared by x, w, bias and output.
- ACC_W, 24: signed accumulator width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a full layer pass.
- bh_flat  in  8*N_HID  signed biases; neuron k uses bits [8k+7:8k].
- x_addr  out  clog2(N_IN)  feature read address.
- x_data  in  8  signed feature; combinational, valid in the same cycle as x_addr.
- w_addr  out  clog2(N_IN*N_HID)  weight address, equal to k*N_IN+i.
- w_data  in  8  signed weight; combinational, same cycle.
- busy  out  1  high from start acceptance until done.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  8  signed activation.
- out_idx  out  clog2(N_HID)  neuron index of out_data.
- done  out  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy, out_valid, done, out_data, out_idx, x_addr, w_addr and the accumulator are all 0.
- IDLE:
  - start=1 sets busy=1, neuron k=0, and moves to BIAS.
  - start is ignored in every other state.
- BIAS (1 cycle):
  - acc <= sign_extend(bh_k) << FRAC_BITS.
  - i=0; x_addr=0, w_addr=k*N_IN.
  - Next state ACC.
- ACC (N_IN cycles):
  - acc <= acc + x_data*w_data, using a signed 16-bit product sign-extended to ACC_W.
  - i increments; addresses track i.
  - The accumulator wraps modulo 2^ACC_W. This cannot occur at the defaults.
  - After i=N_IN-1, go to OUT.
- OUT:
  - Register r = acc >>> FRAC_BITS (arithmetic shift).
  - Apply activation (see Optional Feature).
  - Saturate to [-128,127]; drive out_data, out_idx=k, out_valid=1.
  - Hold all outputs stable while out_ready=0.
  - On out_valid & out_ready: drop out_valid. If k<N_HID-1, then k++ and go to BIAS; otherwise go to IDLE with done=1 for one cycle and busy=0.
- Timing:
  - First out_valid asserts N_IN+2 cycles after the start cycle.
  - With out_ready held high, total latency is N_HID*(N_IN+2) cycles, and done asserts on the following cycle.
- bh_flat, x_data and w_data are sampled only in the cycles they are used. They must stay stable while busy.
- If rst_n asserts mid-pass, everything clears immediately. The pass is aborted and no done is generated.
- start in the same cycle as done's state transition into IDLE is not accepted; start is accepted from the next cycle.

Optional Feature:
- Macro HIDDEN_MAC_RELU_EN.
- Defined: ReLU is applied before saturation. Negative r gives out_data=0; the output range is [0,127].
- Undefined: no activation. r is saturated to signed [-128,127].

Test Plan:
- N_IN=4; all x=16 and w=16; all biases 0; out_ready=1 → each out_data=64, out_idx 0..29 in order, done asserts 181 cycles after start.
- N_IN=4; x=16, w=16; bias0=0x34 (52) → out_data[0]=116 (0x74).
- N_IN=4; x=127, w=127, bias 0x7F → the sum overflows 8 bits and out_data saturates to 127.
- N_IN=4; x=16, w=-16 (0xF0); bias=0xFF:
  - With the macro: out_data=0.
  - Without it: (-1024-16)>>>4 = -65, so out_data=0xBF.
- out_ready held 0 for 10 cycles at neuron 3 → out_data and out_idx=3 stay stable, x_addr and w_addr are frozen, and the pass completes normally after release.
- rst_n pulsed low during ACC of neuron 7 → all outputs are 0 immediately, no done; a new start then produces neuron 0 first.
